// File: rtl/nf_dbg_pkg.sv
// rtl/nf_dbg_pkg.sv - shared states, modes and sizing helper for the debug sampler
package nf_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAMP = 2'd1,
        ST_DONE = 2'd2
    } dbg_state_t;

    localparam logic MODE_CIRC    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    function automatic int ptr_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/nf_dbg_ram.sv
// rtl/nf_dbg_ram.sv - simple dual-port sample buffer, synchronous write, registered read
module nf_dbg_ram
    import nf_dbg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = ptr_w(DEPTH)
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Array left unreset so it can map onto distributed or block RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk1) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/nf_dbg_sampler.sv
// rtl/nf_dbg_sampler.sv - multi-channel sample-and-hold capture with buffered read-out
module nf_dbg_sampler
    import nf_dbg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CH_NUM = 2,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 8,
    localparam int W     = CH_NUM * DATA_W,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             mode,
    input  logic             arm,
    input  logic             stop,
    input  logic             rd_req,
    output logic [W-1:0]     rd_data,
    output logic             rd_valid,
    output logic [W-1:0]     hold_q,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic [1:0]       state
);

    dbg_state_t       st, st_nxt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] divider;
    logic             mode_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             tick;
    logic             full;
    logic             rd_en;

    // arm takes priority over both a pending sample and a pending read.
    assign tick  = (st == ST_SAMP) && (divider == div_q) && !arm;
    assign full  = (count == CW'(DEPTH));
    assign rd_en = rd_req && (st == ST_DONE) && (count != '0) && !arm;
    assign state = st;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) st <= ST_IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (arm) begin
            st_nxt = ST_SAMP;
        end else begin
            case (st)
                ST_SAMP: begin
                    if (stop)
                        st_nxt = ST_DONE;
                    else if (tick && (mode_q == MODE_ONESHOT) && (count == CW'(DEPTH - 1)))
                        st_nxt = ST_DONE;
                end
                default: st_nxt = st;
            endcase
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            mode_q   <= MODE_CIRC;
            divider  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            hold_q   <= '0;
            rd_valid <= 1'b0;
        end else if (arm) begin
            div_q    <= div_cfg;
            mode_q   <= mode;
            divider  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (st == ST_SAMP)
                divider <= (divider == div_q) ? '0 : divider + DIV_W'(1);
            if (tick) begin
                hold_q <= din;
                wr_ptr <= wr_ptr + PW'(1);
                if (full) begin
                    // Circular overwrite: drop the oldest entry.
                    rd_ptr <= rd_ptr + PW'(1);
                    ovf    <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
                count  <= count - CW'(1);
            end
        end
    end

    nf_dbg_ram #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk1    (clk1),
        .rst     (rst),
        .wr_en   (tick),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_nf_dbg_sampler.sv
// tb/tb_nf_dbg_sampler.sv - directed self-checking bench for nf_dbg_sampler
module tb_nf_dbg_sampler;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] din = '0;
    logic [7:0]  div_cfg = '0;
    logic        mode = 1'b0, arm = 1'b0, stop = 1'b0, rd_req = 1'b0;
    logic [15:0] rd_data, hold_q;
    logic        rd_valid, ovf;
    logic [2:0]  count;
    logic [1:0]  state;

    logic [63:0] din6 = '0;
    logic [3:0]  div_cfg6 = '0;
    logic        mode6 = 1'b0, arm6 = 1'b0, stop6 = 1'b0, rd_req6 = 1'b0;
    logic [63:0] rd_data6, hold_q6;
    logic        rd_valid6, ovf6;
    logic [4:0]  count6;
    logic [1:0]  state6;

    int total = 0;
    int bad   = 0;

    always #5 clk1 = ~clk1;

    nf_dbg_sampler #(.DATA_W(8), .CH_NUM(2), .DEPTH(4), .DIV_W(8)) dut (
        .clk1(clk1), .rst(rst), .din(din), .div_cfg(div_cfg), .mode(mode),
        .arm(arm), .stop(stop), .rd_req(rd_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .hold_q(hold_q), .count(count), .ovf(ovf), .state(state)
    );

    nf_dbg_sampler #(.DATA_W(8), .CH_NUM(4), .DEPTH(16), .DIV_W(4)) dut6 (
        .clk1(clk1), .rst(rst), .din(din6), .div_cfg(div_cfg6), .mode(mode6),
        .arm(arm6), .stop(stop6), .rd_req(rd_req6), .rd_data(rd_data6),
        .rd_valid(rd_valid6), .hold_q(hold_q6), .count(count6), .ovf(ovf6), .state(state6)
    );

    task automatic cyc();
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
        total++; if (hold_q !== 16'h0) begin bad++; $display("FAIL reset_hold got=%h exp=0000", hold_q); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        total++; if (state6 !== 2'd0) begin bad++; $display("FAIL reset_state6 got=%0d exp=0", state6); end
        @(posedge clk1); #1; rst = 1'b0;
    endtask

    task automatic test_reset_mid_samp();
        mode = 1'b0; div_cfg = 8'd0; din = 16'hBEEF; arm = 1'b1; cyc(); arm = 1'b0;
        for (int j = 0; j < 5; j++) cyc();
        total++; if (hold_q !== 16'hBEEF) begin bad++; $display("FAIL midrst_pre_hold got=%h exp=beef", hold_q); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL midrst_pre_ovf got=%0b exp=1", ovf); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL midrst_pre_count got=%0d exp=4", count); end
        #2 rst = 1'b1;
        #1;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL midrst_state got=%0d exp=0", state); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", count); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%0b exp=0", ovf); end
        total++; if (hold_q !== 16'h0) begin bad++; $display("FAIL midrst_hold got=%h exp=0000", hold_q); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_rd_valid got=%0b exp=0", rd_valid); end
        @(posedge clk1); #1; rst = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [15:0] exp_q [4];
        exp_q[0] = 16'h0103; exp_q[1] = 16'h0106; exp_q[2] = 16'h0109; exp_q[3] = 16'h010C;
        mode = 1'b1; div_cfg = 8'd2; din = 16'h0100; arm = 1'b1; cyc(); arm = 1'b0;
        total++; if (state !== 2'd1) begin bad++; $display("FAIL os_arm_state got=%0d exp=1", state); end
        for (int j = 1; j <= 12; j++) begin
            din = 16'h0100 + 16'(j);
            cyc();
            if (j == 3) begin
                total++; if (count !== 3'd1) begin bad++; $display("FAIL os_first_tick got=%0d exp=1", count); end
            end
            if (j == 11) begin
                total++; if (state !== 2'd1 || count !== 3'd3) begin bad++; $display("FAIL os_pre_done state=%0d count=%0d exp=1/3", state, count); end
            end
        end
        total++; if (state !== 2'd2) begin bad++; $display("FAIL os_done_state got=%0d exp=2", state); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL os_done_count got=%0d exp=4", count); end
        total++; if (hold_q !== 16'h010C) begin bad++; $display("FAIL os_hold got=%h exp=010c", hold_q); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL os_idle_valid got=%0b exp=0", rd_valid); end
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; cyc();
            total++; if (rd_valid !== 1'b1 || rd_data !== exp_q[i]) begin bad++; $display("FAIL os_read%0d valid=%0b data=%h exp=1/%h", i, rd_valid, rd_data, exp_q[i]); end
        end
        cyc();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL os_read_empty valid=%0b exp=0", rd_valid); end
        total++; if (count !== 3'd0 || state !== 2'd2) begin bad++; $display("FAIL os_empty count=%0d state=%0d exp=0/2", count, state); end
        rd_req = 1'b0;
    endtask

    task automatic test_circular_wrap();
        mode = 1'b0; div_cfg = 8'd0; arm = 1'b1; cyc(); arm = 1'b0;
        for (int j = 0; j < 10; j++) begin
            din = 16'(j); stop = (j == 9); cyc();
        end
        stop = 1'b0;
        total++; if (state !== 2'd2) begin bad++; $display("FAIL circ_state got=%0d exp=2", state); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL circ_count got=%0d exp=4", count); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL circ_ovf got=%0b exp=1", ovf); end
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; cyc();
            total++; if (rd_valid !== 1'b1 || rd_data !== 16'(6 + i)) begin bad++; $display("FAIL circ_read%0d valid=%0b data=%h exp=1/%h", i, rd_valid, rd_data, 16'(6 + i)); end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_stop_on_tick();
        mode = 1'b0; div_cfg = 8'd1; arm = 1'b1; cyc(); arm = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            din = 16'h00A0 + 16'(j); stop = (j == 6); cyc();
        end
        stop = 1'b0;
        total++; if (state !== 2'd2) begin bad++; $display("FAIL stop_state got=%0d exp=2", state); end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL stop_count got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1; cyc();
            total++; if (rd_valid !== 1'b1 || rd_data !== 16'h00A2 + 16'(2 * i)) begin bad++; $display("FAIL stop_read%0d valid=%0b data=%h exp=1/%h", i, rd_valid, rd_data, 16'h00A2 + 16'(2 * i)); end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_ignored_requests();
        mode = 1'b0; div_cfg = 8'd3; din = 16'h5A5A; arm = 1'b1; cyc(); arm = 1'b0;
        for (int j = 0; j < 4; j++) cyc();
        rd_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cyc();
            total++; if (rd_valid !== 1'b0 || count !== 3'd1) begin bad++; $display("FAIL ign_samp%0d valid=%0b count=%0d exp=0/1", j, rd_valid, count); end
        end
        rd_req = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        rd_req = 1'b1; cyc(); rd_req = 1'b0;
        total++; if (rd_valid !== 1'b0 || state !== 2'd0) begin bad++; $display("FAIL ign_idle valid=%0b state=%0d exp=0/0", rd_valid, state); end
        div_cfg = 8'd0; arm = 1'b1; cyc(); arm = 1'b0;
        din = 16'h1111; cyc();
        din = 16'h2222; stop = 1'b1; cyc(); stop = 1'b0;
        total++; if (state !== 2'd2 || count !== 3'd2) begin bad++; $display("FAIL ign_pre_done state=%0d count=%0d exp=2/2", state, count); end
        arm = 1'b1; rd_req = 1'b1; cyc(); arm = 1'b0; rd_req = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ign_arm_rd valid=%0b exp=0", rd_valid); end
        total++; if (count !== 3'd0 || state !== 2'd1) begin bad++; $display("FAIL ign_arm_state count=%0d state=%0d exp=0/1", count, state); end
        cyc();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ign_arm_late valid=%0b exp=0", rd_valid); end
        total++; if (hold_q !== 16'h2222) begin bad++; $display("FAIL ign_arm_hold got=%h exp=2222", hold_q); end
    endtask

    task automatic test_param_sweep();
        logic [7:0] e;
        mode6 = 1'b1; div_cfg6 = 4'd15; arm6 = 1'b1; cyc(); arm6 = 1'b0;
        for (int j = 1; j <= 256; j++) begin
            for (int k = 0; k < 4; k++) din6[k*8 +: 8] = 8'(j + 37 * k);
            cyc();
            if (j == 255) begin
                total++; if (state6 !== 2'd1 || count6 !== 5'd15) begin bad++; $display("FAIL p6_pre_done state=%0d count=%0d exp=1/15", state6, count6); end
            end
        end
        total++; if (state6 !== 2'd2 || count6 !== 5'd16) begin bad++; $display("FAIL p6_done state=%0d count=%0d exp=2/16", state6, count6); end
        for (int i = 0; i < 16; i++) begin
            rd_req6 = 1'b1; cyc();
            total++; if (rd_valid6 !== 1'b1) begin bad++; $display("FAIL p6_valid%0d got=%0b exp=1", i, rd_valid6); end
            for (int k = 0; k < 4; k++) begin
                e = 8'(16 * (i + 1) + 37 * k);
                total++; if (rd_data6[k*8 +: 8] !== e) begin bad++; $display("FAIL p6_e%0d_ch%0d got=%h exp=%h", i, k, rd_data6[k*8 +: 8], e); end
            end
        end
        rd_req6 = 1'b0; cyc();
        total++; if (rd_valid6 !== 1'b0 || count6 !== 5'd0) begin bad++; $display("FAIL p6_empty valid=%0b count=%0d exp=0/0", rd_valid6, count6); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_mid_samp();
        test_oneshot();
        test_circular_wrap();
        test_stop_on_tick();
        test_ignored_requests();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
